// File: rtl/fv_cmt_window_tracker.sv
// ----------------------------------------------------------------------------
// fv_cmt_window_tracker
//   Multi-channel commit/liveness tracker for the FV core harness. It opens a
//   one-shot window when the saturating clock reaches START_CYCLE. It counts
//   per-channel commits over WINDOW counted cycles. It then reports, per channel,
//   whether at least MIN_COMMIT instructions committed.
//
//   Optional feature macro: FV_CMT_STALL_EXCLUDE_EN
//     defined   -> cycles where every stall bit is 1 are not counted in WINDOW
//     undefined -> stall is ignored
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   enable             0 freezes window progress (counters still run)
//   commit             per-channel commit bits, channel c = [c*COMMIT_W +: COMMIT_W]
//   stall, kill        per-channel stall / kill (kill drops that cycle's commits)
//   clock_counter_ns   free-running wrapping cycle counter
//   clock_counter      saturating cycle counter, cap START_CYCLE+WINDOW+2
//   fv_init            clock_counter == 0
//   num_committed      per-channel saturating commit totals, channel c = [c*CNT_W +: CNT_W]
//   window_cnt         counted cycles elapsed in the window
//   state              0 IDLE, 1 WINDOW, 2 CHECK, 3 DONE
//   check_valid        one-cycle pulse while in CHECK
//   check_pass         per-channel result, valid from CHECK, held in DONE
// ----------------------------------------------------------------------------

// Per-channel accumulator and result register.
module fv_cmt_lane #(
    parameter int COMMIT_W   = 2,
    parameter int CNT_W      = 10,
    parameter int MIN_COMMIT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                count_en,
    input  logic                latch,
    input  logic [COMMIT_W-1:0] commit,
    input  logic                kill,
    output logic [CNT_W-1:0]    num_committed,
    output logic                check_pass
);
    localparam int ADD_W = $clog2(COMMIT_W + 1);
    localparam int SUM_W = CNT_W + ADD_W;
    localparam logic [SUM_W-1:0] MAX_CNT = {{ADD_W{1'b0}}, {CNT_W{1'b1}}};

    logic [ADD_W-1:0] add;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] nxt;

    always_comb begin
        add = kill ? '0 : ADD_W'($countones(commit));
        sum = SUM_W'(num_committed) + SUM_W'(add);
        nxt = num_committed;
        if (count_en)
            nxt = (sum > MAX_CNT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_committed <= '0;
            check_pass    <= 1'b0;
        end else if (clear) begin
            num_committed <= '0;
        end else begin
            num_committed <= nxt;
            // Result is taken from the final accumulated value. It lands in
            // the same cycle that CHECK is entered.
            if (latch)
                check_pass <= (int'(nxt) >= MIN_COMMIT);
        end
    end
endmodule

module fv_cmt_window_tracker #(
    parameter int NUM_CH      = 1,
    parameter int COMMIT_W    = 2,
    parameter int CNT_W       = 10,
    parameter int START_CYCLE = 2,
    parameter int WINDOW      = 20,
    parameter int MIN_COMMIT  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_CH*COMMIT_W-1:0] commit,
    input  logic [NUM_CH-1:0]          stall,
    input  logic [NUM_CH-1:0]          kill,
    output logic [CNT_W-1:0]           clock_counter_ns,
    output logic [CNT_W-1:0]           clock_counter,
    output logic                       fv_init,
    output logic [NUM_CH*CNT_W-1:0]    num_committed,
    output logic [CNT_W-1:0]           window_cnt,
    output logic [1:0]                 state,
    output logic                       check_valid,
    output logic [NUM_CH-1:0]          check_pass
);
    localparam int CAP = START_CYCLE + WINDOW + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WINDOW = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t st;
    logic   start;
    logic   counted;
    logic   last;

`ifdef FV_CMT_STALL_EXCLUDE_EN
    // A fully stalled machine does not use up window time.
    assign counted = (st == S_WINDOW) && enable && !(&stall);
`else
    logic unused_stall;
    assign unused_stall = ^stall;
    assign counted      = (st == S_WINDOW) && enable;
`endif

    assign start   = (st == S_IDLE) && enable && (clock_counter == CNT_W'(START_CYCLE));
    assign last    = counted && (window_cnt == CNT_W'(WINDOW - 1));
    assign fv_init = (clock_counter == '0);
    assign state   = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            clock_counter_ns <= '0;
            clock_counter    <= '0;
            window_cnt       <= '0;
            check_valid      <= 1'b0;
            st               <= S_IDLE;
        end else begin
            clock_counter_ns <= clock_counter_ns + 1'b1;
            if (clock_counter < CNT_W'(CAP))
                clock_counter <= clock_counter + 1'b1;
            check_valid <= 1'b0;
            case (st)
                // If enable is low at START_CYCLE, the clock moves past the start value.
                // The tracker then stays in IDLE until reset.
                S_IDLE: if (start) begin
                    st         <= S_WINDOW;
                    window_cnt <= '0;
                end
                S_WINDOW: begin
                    if (counted)
                        window_cnt <= window_cnt + 1'b1;
                    if (last) begin
                        st          <= S_CHECK;
                        check_valid <= 1'b1;
                    end
                end
                S_CHECK: st <= S_DONE;
                default: st <= S_DONE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        fv_cmt_lane #(
            .COMMIT_W  (COMMIT_W),
            .CNT_W     (CNT_W),
            .MIN_COMMIT(MIN_COMMIT)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .clear        (start),
            .count_en     (counted),
            .latch        (last),
            .commit       (commit[g*COMMIT_W +: COMMIT_W]),
            .kill         (kill[g]),
            .num_committed(num_committed[g*CNT_W +: CNT_W]),
            .check_pass   (check_pass[g])
        );
    end
endmodule
